// File: rtl/axil_pkg.sv
// Shared constants, FSM state encodings and helpers for the AXI4-Lite register responder.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_HAVE_A = 3'd1,
        W_HAVE_D = 3'd2,
        W_COMMIT = 3'd3,
        W_RESP   = 3'd4
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Ceiling log2 with a fixed loop bound so it elaborates as a constant.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) with master and slave views.
interface axil_reg_slave_if #(
    parameter int AW = 12
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    // Every channel transfers on a clock edge where valid and ready are both high;
    // valid never waits on ready, and a raised valid holds its payload until that edge.
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axil_regfile.sv
// NREGS x 32 register array: one byte-enabled synchronous write port, one read-before-write read port.
module axil_regfile #(
    parameter int NREGS = 16,
    parameter int IW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    output logic [31:0]   wr_merged,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [NREGS];

    // Value the addressed register will hold once the write lands.
    always_comb begin
        wr_merged = mem[wr_idx];
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (rd_en) rd_data <= mem[rd_idx];
            if (wr_en) mem[wr_idx] <= wr_merged;
        end
    end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register responder with independent write/read FSMs and a commit notification.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int AW    = 12,
    parameter int NREGS = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    axil_reg_slave_if.slave           bus,
    output logic                      o_wr_stb,
    output logic [clog2(NREGS)-1:0]   o_wr_idx,
    output logic [31:0]               o_wr_data,
    output w_state_t                  o_dbg_wstate,
    output r_state_t                  o_dbg_rstate
);

    localparam int IW = clog2(NREGS);

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    function automatic logic out_of_range(input logic [AW-1:0] a);
        return |(a >> (IW + 2));
    endfunction

    // ---------------- write channel ----------------
    w_state_t      w_state, w_next;
    logic          awready_q, wready_q, bvalid_q;
    logic [1:0]    bresp_q;
    logic [IW-1:0] w_idx_q;
    logic          w_oor_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          aw_hs, w_hs, rf_wr_en;
    logic [31:0]   rf_merged;

    assign aw_hs = bus.awvalid & awready_q;
    assign w_hs  = bus.wvalid & wready_q;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_COMMIT;
                else if (aw_hs)    w_next = W_HAVE_A;
                else if (w_hs)     w_next = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)  w_next = W_COMMIT;
            W_HAVE_D: if (aw_hs) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (bus.bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    // Readies and bvalid are registered copies of what the next state allows.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_oor_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
            wready_q  <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
            bvalid_q  <= (w_next == W_RESP);
            if (w_state == W_COMMIT) bresp_q <= w_oor_q ? OOR_RESP : RESP_OKAY;
            if (aw_hs) begin
                w_idx_q <= bus.awaddr[IW+1:2];
                w_oor_q <= out_of_range(bus.awaddr);
            end
            if (w_hs) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
        end
    end

    assign rf_wr_en  = (w_state == W_COMMIT) && !w_oor_q;
    assign o_wr_stb  = rf_wr_en;
    assign o_wr_idx  = w_idx_q;
    assign o_wr_data = rf_merged;

    // ---------------- read channel ----------------
    r_state_t      r_state, r_next;
    logic          arready_q, rvalid_q;
    logic [1:0]    rresp_q;
    logic [IW-1:0] r_idx_q;
    logic          r_oor_q;
    logic          ar_hs, rd_sample;
    logic [31:0]   rf_rdata;

    assign ar_hs = bus.arvalid & arready_q;
    // First R_DATA cycle samples the array; rvalid rises on that same edge.
    assign rd_sample = (r_state == R_DATA) && !rvalid_q;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (rvalid_q && bus.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            r_idx_q   <= '0;
            r_oor_q   <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (rd_sample) begin
                rvalid_q <= 1'b1;
                rresp_q  <= r_oor_q ? OOR_RESP : RESP_OKAY;
            end else if (rvalid_q && bus.rready) begin
                rvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                r_idx_q <= bus.araddr[IW+1:2];
                r_oor_q <= out_of_range(bus.araddr);
            end
        end
    end

    axil_regfile #(
        .NREGS (NREGS),
        .IW    (IW)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .wr_en     (rf_wr_en),
        .wr_idx    (w_idx_q),
        .wr_data   (wdata_q),
        .wr_strb   (wstrb_q),
        .wr_merged (rf_merged),
        .rd_en     (rd_sample),
        .rd_idx    (r_idx_q),
        .rd_data   (rf_rdata)
    );

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = r_oor_q ? 32'h0 : rf_rdata;
    assign bus.rlast   = 1'b1;

    assign o_dbg_wstate = w_state;
    assign o_dbg_rstate = r_state;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized bench for axil_reg_slave against an array model of the register file.
module tb_axil_reg_slave;
    import axil_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_reg_slave_if #(.AW(12)) bus();

    logic        wr_stb;
    logic [3:0]  wr_idx;
    logic [31:0] wr_data;
    w_state_t    dbg_w;
    r_state_t    dbg_r;

    axil_reg_slave #(.AW(12), .NREGS(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_wr_stb     (wr_stb),
        .o_wr_idx     (wr_idx),
        .o_wr_data    (wr_data),
        .o_dbg_wstate (dbg_w),
        .o_dbg_rstate (dbg_r)
    );

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic [31:0] model [16];
    logic [31:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic bit is_oor(input logic [11:0] a);
        return a[11:6] != 6'd0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int bdly);
        bit aw_done, w_done, aw_fire, w_fire, inr;
        int cyc, aw_start, w_start, idx;
        logic [31:0] merged;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        inr = !is_oor(addr);
        idx = int'(addr[5:2]);
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        exp_resp = inr ? 2'b00 : OOR_RESP;
        while (!(aw_done && w_done) && cyc < 50) begin
            bus.awvalid = !aw_done && (cyc >= aw_start);
            bus.awaddr  = addr;
            bus.wvalid  = !w_done && (cyc >= w_start);
            bus.wdata   = data;
            bus.wstrb   = strb;
            if (w_done && !aw_done) begin
                n_cmp++;
                if (bus.wready !== 1'b0) begin
                    n_err++;
                    $display("FAIL wready_after_w: got %b expected 0", bus.wready);
                end
            end
            if (aw_done && !w_done) begin
                n_cmp++;
                if (bus.awready !== 1'b0) begin
                    n_err++;
                    $display("FAIL awready_after_aw: got %b expected 0", bus.awready);
                end
            end
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            tick();
            cyc++;
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            n_cmp++; n_err++;
            $display("FAIL write_timeout: addr %h not accepted in 50 cycles", addr);
            return;
        end
        // Commit cycle.
        merged = merge(model[idx], data, strb);
        n_cmp++;
        if (inr) begin
            if ({wr_stb, wr_idx, wr_data} !== {1'b1, 4'(idx), merged}) begin
                n_err++;
                $display("FAIL commit_notify: got stb=%b idx=%0d data=%h expected stb=1 idx=%0d data=%h",
                         wr_stb, wr_idx, wr_data, idx, merged);
            end
            model[idx] = merged;
        end else if (wr_stb !== 1'b0) begin
            n_err++;
            $display("FAIL commit_oor_stb: got %b expected 0", wr_stb);
        end
        n_cmp++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b000) begin
            n_err++;
            $display("FAIL commit_handshake: got bvalid/awready/wready=%b expected 000",
                     {bus.bvalid, bus.awready, bus.wready});
        end
        tick();
        n_cmp++;
        if ({bus.bvalid, bus.bresp, wr_stb} !== {1'b1, exp_resp, 1'b0}) begin
            n_err++;
            $display("FAIL bresp: got bvalid=%b bresp=%b stb=%b expected 1 %b 0",
                     bus.bvalid, bus.bresp, wr_stb, exp_resp);
        end
        for (int i = 0; i < bdly; i++) begin
            tick();
            n_cmp++;
            if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== {1'b1, exp_resp, 2'b00}) begin
                n_err++;
                $display("FAIL b_stall: got bvalid=%b bresp=%b awready=%b wready=%b expected 1 %b 0 0",
                         bus.bvalid, bus.bresp, bus.awready, bus.wready, exp_resp);
            end
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        n_cmp++;
        if ({bus.bvalid, bus.awready, bus.wready} !== 3'b011) begin
            n_err++;
            $display("FAIL b_done: got bvalid/awready/wready=%b expected 011",
                     {bus.bvalid, bus.awready, bus.wready});
        end
    endtask

    task automatic do_read(input logic [11:0] addr, input int hold);
        bit fired;
        int cyc;
        logic [31:0] exp_data, got;
        logic [1:0] exp_resp;
        exp_q.push_back(is_oor(addr) ? 32'h0 : model[addr[5:2]]);
        exp_resp = is_oor(addr) ? OOR_RESP : 2'b00;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        fired = 0; cyc = 0;
        while (!fired && cyc < 20) begin
            fired = bus.arready;
            tick();
            cyc++;
        end
        bus.arvalid = 1'b0;
        if (!fired) begin
            n_cmp++; n_err++;
            $display("FAIL read_timeout: addr %h not accepted in 20 cycles", addr);
            void'(exp_q.pop_back());
            return;
        end
        n_cmp++;
        if ({bus.rvalid, bus.arready} !== 2'b00) begin
            n_err++;
            $display("FAIL r_latency: got rvalid/arready=%b expected 00", {bus.rvalid, bus.arready});
        end
        tick();
        exp_data = exp_q.pop_front();
        got = bus.rdata;
        n_cmp++;
        if (got !== exp_data) begin
            n_err++;
            $display("FAIL rdata: addr %h got %h expected %h", addr, got, exp_data);
        end
        n_cmp++;
        if ({bus.rvalid, bus.rresp, bus.arready, bus.rlast} !== {1'b1, exp_resp, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL r_ctrl: got rvalid=%b rresp=%b arready=%b rlast=%b expected 1 %b 0 1",
                     bus.rvalid, bus.rresp, bus.arready, bus.rlast, exp_resp);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_cmp++;
            if ({bus.rvalid, bus.rdata, bus.rresp} !== {1'b1, exp_data, exp_resp}) begin
                n_err++;
                $display("FAIL r_stall: got rvalid=%b rdata=%h rresp=%b expected 1 %h %b",
                         bus.rvalid, bus.rdata, bus.rresp, exp_data, exp_resp);
            end
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        n_cmp++;
        if ({bus.rvalid, bus.arready} !== 2'b01) begin
            n_err++;
            $display("FAIL r_done: got rvalid/arready=%b expected 01", {bus.rvalid, bus.arready});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        clear_model();
        repeat (3) tick();
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_stb} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_stb});
        end
        n_cmp++;
        if ({bus.rdata, bus.bresp, bus.rresp, wr_idx, wr_data, bus.rlast} !== {72'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_data: got rdata=%h bresp=%b rresp=%b idx=%h wdata=%h rlast=%b expected zeros, rlast=1",
                     bus.rdata, bus.bresp, bus.rresp, wr_idx, wr_data, bus.rlast);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_release: got %b expected 111", {bus.awready, bus.wready, bus.arready});
        end
    endtask

    task automatic test_same_cycle();
        do_write(12'h008, 32'hDEADBEEF, 4'hF, 0, 0);
        do_read(12'h008, 0);
    endtask

    task automatic test_w_first();
        do_write(12'h00C, 32'hAAAAAAAA, 4'hF, 0, 0);
        do_write(12'h00C, 32'h11223344, 4'b0101, 3, 0);
        do_read(12'h00C, 1);
    endtask

    task automatic test_bready_stall();
        do_write(12'h010, $urandom, 4'hF, -2, 5);
        do_write(12'h014, $urandom, 4'h0, 0, 2);
        do_read(12'h010, 2);
        do_read(12'h014, 0);
    endtask

    task automatic test_out_of_range();
        do_read(12'h040, 1);
        do_write(12'h044, 32'h12345678, 4'hF, 0, 1);
        do_write(12'h800, 32'hCAFEF00D, 4'hF, 1, 0);
        do_read(12'h804, 0);
        do_read(12'h004, 0);
    endtask

    task automatic test_same_edge();
        logic [31:0] old, nw;
        old = model[3];
        nw = $urandom;
        bus.awaddr = 12'h00C; bus.awvalid = 1; bus.wdata = nw; bus.wstrb = 4'hF; bus.wvalid = 1;
        bus.araddr = 12'h00C; bus.arvalid = 1;
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            n_err++;
            $display("FAIL same_edge_ready: got %b expected 111", {bus.awready, bus.wready, bus.arready});
        end
        tick();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        n_cmp++;
        if ({wr_stb, wr_data} !== {1'b1, nw}) begin
            n_err++;
            $display("FAIL same_edge_commit: got stb=%b data=%h expected 1 %h", wr_stb, wr_data, nw);
        end
        model[3] = nw;
        tick();
        n_cmp++;
        if ({bus.rvalid, bus.rdata, bus.bvalid} !== {1'b1, old, 1'b1}) begin
            n_err++;
            $display("FAIL same_edge_old: got rvalid=%b rdata=%h bvalid=%b expected 1 %h 1",
                     bus.rvalid, bus.rdata, bus.bvalid, old);
        end
        bus.rready = 1; bus.bready = 1;
        tick();
        bus.rready = 0; bus.bready = 0;
        n_cmp++;
        if ({bus.rvalid, bus.bvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL same_edge_done: got rvalid/bvalid=%b expected 00", {bus.rvalid, bus.bvalid});
        end
        do_read(12'h00C, 0);
    endtask

    task automatic test_random();
        logic [11:0] addr;
        for (int n = 0; n < 30; n++) begin
            addr = 12'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) addr = addr | 12'(1 << $urandom_range(6, 11));
            if ($urandom_range(0, 1) == 0)
                do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 3));
            else
                do_read(addr, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        do_write(12'h014, 32'h5A5A5A5A, 4'hF, 0, 0);
        bus.awaddr = 12'h018; bus.awvalid = 1;
        bus.araddr = 12'h014; bus.arvalid = 1;
        tick();
        bus.awvalid = 0; bus.arvalid = 0;
        tick();
        n_cmp++;
        if ({dbg_w == W_HAVE_A, dbg_r == R_DATA, bus.rvalid} !== 3'b111) begin
            n_err++;
            $display("FAIL pre_reset_state: got have_a/r_data/rvalid=%b expected 111",
                     {dbg_w == W_HAVE_A, dbg_r == R_DATA, bus.rvalid});
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_stb, bus.rdata} !== 38'h0) begin
            n_err++;
            $display("FAIL mid_reset: got ctrl=%b rdata=%h expected 0",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_stb}, bus.rdata);
        end
        rst = 1'b0;
        clear_model();
        tick();
        n_cmp++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid} !== 4'b1110) begin
            n_err++;
            $display("FAIL post_reset: got %b expected 1110", {bus.awready, bus.wready, bus.arready, bus.bvalid});
        end
        do_read(12'h014, 0);
        do_read(12'h008, 0);
        do_read(12'h00C, 0);
    endtask

    task automatic test_readback_all();
        for (int i = 0; i < 16; i++) do_read(12'(i * 4), 0);
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_bready_stall();
        test_out_of_range();
        test_same_edge();
        test_random();
        test_readback_all();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
